mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters SHALL be: XLEN, 64, register/data width; RA_W, 5, register-address width.
REQ-002 Ports SHALL be: clk  in  1  clock; one clock; all state on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 valid_i  in  1  EX result present this cycle.
REQ-005 rd_addr_i  in  RA_W  destination register from EX.
REQ-006 wreg_i  in  1  destination-write enable from EX.
REQ-007 wdata_i  in  XLEN  EX result; effective address for load/store.
REQ-008 opcode_i  in  7 and funct3_i  in  3  instruction class and width.
REQ-009 store_data_i  in  XLEN  rs2 value for stores.
REQ-010 ready_o  out  1  stage can accept; low stalls EX.
REQ-011 dcache_req_o  out  1, dcache_we_o  out  1, dcache_addr_o  out  XLEN (8-byte aligned), dcache_wdata_o  out  XLEN, dcache_wmask_o  out  8  request channel to data memory.
REQ-012 dcache_gnt_i  in  1, dcache_rvalid_i  in  1, dcache_rdata_i  in  XLEN  grant and read-return channel.
REQ-013 rd_addr_o  out  RA_W, wreg_o  out  1, wdata_o  out  XLEN  registered result to WB.
REQ-014 mem_back_rd_addr_o  out  RA_W, mem_back_wreg_o  out  1, mem_back_wdata_o  out  XLEN  forwarding to EX.
REQ-015 misalign_o  out  1  one-cycle pulse on a misaligned access.

Function
REQ-016 Load is opcode 0000011 and store is opcode 0100011; every other valid_i is a pass-through.
REQ-017 FSM states SHALL be IDLE, REQ and WAIT; ready_o SHALL be 1 only in IDLE.
REQ-018 Pass-through SHALL have 1-cycle latency: rd_addr_o=rd_addr_i, wdata_o=wdata_i, wreg_o=wreg_i on the next edge; the FSM stays in IDLE.
REQ-019 A load or store accepted in IDLE SHALL latch address, size, sign, rd and store data, then enter REQ.
REQ-020 In REQ: dcache_req_o=1, addr={wdata[63:3],3'b000}, and addr/we/wdata/wmask SHALL be held stable until dcache_gnt_i=1.
REQ-021 On grant, a store SHALL go to IDLE and complete with wreg_o=0; a load SHALL go to WAIT.
REQ-022 WAIT SHALL hold until dcache_rvalid_i=1; rvalid in the grant cycle SHALL be accepted directly, REQ->IDLE.
REQ-023 Load data SHALL be selected by lane off=addr[2:0] (rdata >> 8*off), truncated to the access size, then sign- or zero-extended to 64 bits.
REQ-024 Load funct3 decodes SHALL be: LB 000 sign, LH 001 sign, LW 010 sign, LD 011, LBU 100 zero, LHU 101 zero, LWU 110 zero.
REQ-025 The load result SHALL appear on wdata_o with wreg_o=1 one cycle after the rvalid edge.
REQ-026 Store funct3 decodes SHALL be: SB 000, SH 001, SW 010, SD 011.
REQ-027 Store wdata SHALL be store_data shifted left by 8*off; wmask SHALL be the size mask shifted left by off (SB 0x01, SH 0x03, SW 0x0F, SD 0xFF).
REQ-028 Misaligned accesses (H with off[0]!=0, W with off[1:0]!=0, D with off!=0) SHALL issue no request, pulse misalign_o for 1 cycle, give wreg_o=0, and leave the FSM in IDLE.
REQ-029 rd_addr=0 SHALL force wreg_o=0 for every class.
REQ-030 When no result is produced in a cycle (bubble, stall, store), wreg_o SHALL be 0 and wdata_o SHALL hold its prior value.
REQ-031 mem_back_* SHALL equal the rd_addr_o/wreg_o/wdata_o outputs combinationally.
REQ-032 dcache_rvalid_i SHALL be ignored in IDLE and REQ (except the grant cycle); dcache_gnt_i SHALL be ignored outside REQ.
REQ-033 valid_i while ready_o=0 SHALL be ignored; upstream holds the instruction.

Reset
REQ-034 rst SHALL force state IDLE, and wreg_o, wdata_o, rd_addr_o, dcache_req_o, dcache_we_o, dcache_wmask_o, misalign_o to 0.
REQ-035 rst SHALL force ready_o=1.
REQ-036 rst during REQ or WAIT SHALL abandon the access: dcache_req_o=0 next cycle, a late rvalid is discarded, and no result is written.

Verification
REQ-037 ADD pass-through, rd=5, wdata_i=0x1234 -> next cycle wreg_o=1, rd_addr_o=5, wdata_o=0x1234, mem_back_* equal.
REQ-038 LB addr 0x1003, gnt after 2 cycles, rdata=0x00000000_80000000 -> wdata_o=0xFFFFFFFF_FFFFFF80, ready_o low from the accept edge to the result edge; LBU same -> 0x80.
REQ-039 SH addr 0x2006, store_data=0xBEEF -> wmask=0xC0, wdata=0xBEEF<<48, addr=0x2000, held 3 cycles until gnt, wreg_o=0.
REQ-040 LW addr 0x3002 -> misalign_o pulse, no dcache_req_o, wreg_o=0, ready_o stays 1.
REQ-041 LD in WAIT, rst asserted one cycle, then rvalid arrives -> state IDLE, wreg_o=0, rvalid ignored.
REQ-042 LD to rd=0, rdata=0xFFFF -> wreg_o=0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: load/store unit between EX and WB.
// Drives the data cache, aligns loads, and registers results for WB.
module mem_stage #(
  parameter int XLEN = 64,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [RA_W-1:0] rd_addr_i,
  input  logic            wreg_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] store_data_i,
  output logic            ready_o,
  output logic            dcache_req_o,
  output logic            dcache_we_o,
  output logic [XLEN-1:0] dcache_addr_o,
  output logic [XLEN-1:0] dcache_wdata_o,
  output logic [7:0]      dcache_wmask_o,
  input  logic            dcache_gnt_i,
  input  logic            dcache_rvalid_i,
  input  logic [XLEN-1:0] dcache_rdata_i,
  output logic [RA_W-1:0] rd_addr_o,
  output logic            wreg_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [RA_W-1:0] mem_back_rd_addr_o,
  output logic            mem_back_wreg_o,
  output logic [XLEN-1:0] mem_back_wdata_o,
  output logic            misalign_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  state_t r_state;
  state_t w_next;

  logic [XLEN-1:0] r_addr;
  logic [2:0]      r_f3;
  logic [RA_W-1:0] r_rd;
  logic [XLEN-1:0] r_sdata;
  logic            r_st;

  logic [RA_W-1:0] r_rd_out;
  logic            r_wreg;
  logic [XLEN-1:0] r_wdata;
  logic            r_mis;

  logic            w_idle;
  logic            w_ldst;
  logic [2:0]      w_off;
  logic            w_mis;
  logic            w_accept;
  logic [2:0]      w_roff;
  logic [7:0]      w_size_mask;
  logic [XLEN-1:0] w_lsh;
  logic [XLEN-1:0] w_ld;
  logic            w_ld_done;

  assign w_idle   = (r_state == S_IDLE);
  assign w_ldst   = (opcode_i == OP_LOAD) || (opcode_i == OP_STORE);
  assign w_off    = wdata_i[2:0];
  assign w_accept = w_idle && valid_i && w_ldst && !w_mis;
  assign w_roff   = r_addr[2:0];

  // Alignment check of the incoming access against its size.
  always_comb begin
    w_mis = 1'b0;
    unique case (funct3_i[1:0])
      2'd1:    w_mis = w_off[0];
      2'd2:    w_mis = |w_off[1:0];
      2'd3:    w_mis = |w_off;
      default: w_mis = 1'b0;
    endcase
  end

  // Byte-enable pattern for the latched access size.
  always_comb begin
    w_size_mask = 8'h00;
    unique case (r_f3[1:0])
      2'd0:    w_size_mask = 8'h01;
      2'd1:    w_size_mask = 8'h03;
      2'd2:    w_size_mask = 8'h0F;
      default: w_size_mask = 8'hFF;
    endcase
  end

  assign w_lsh = dcache_rdata_i >> {w_roff, 3'b000};

  // Lane-select, truncate and extend the returned load data.
  always_comb begin
    w_ld = w_lsh;
    unique case (r_f3)
      3'b000:  w_ld = {{(XLEN-8){w_lsh[7]}}, w_lsh[7:0]};
      3'b001:  w_ld = {{(XLEN-16){w_lsh[15]}}, w_lsh[15:0]};
      3'b010:  w_ld = {{(XLEN-32){w_lsh[31]}}, w_lsh[31:0]};
      3'b100:  w_ld = {{(XLEN-8){1'b0}}, w_lsh[7:0]};
      3'b101:  w_ld = {{(XLEN-16){1'b0}}, w_lsh[15:0]};
      3'b110:  w_ld = {{(XLEN-32){1'b0}}, w_lsh[31:0]};
      default: w_ld = w_lsh;
    endcase
  end

  assign w_ld_done =
    (!r_st && dcache_rvalid_i) &&
    (((r_state == S_REQ) && dcache_gnt_i) || (r_state == S_WAIT));

  // Next-state logic of the access sequencer.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = S_REQ;
      S_REQ: begin
        if (dcache_gnt_i) begin
          if (r_st || dcache_rvalid_i) w_next = S_IDLE;
          else w_next = S_WAIT;
        end
      end
      S_WAIT: if (dcache_rvalid_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  end

  // Capture the access parameters when a load/store is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_f3    <= '0;
      r_rd    <= '0;
      r_sdata <= '0;
      r_st    <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= wdata_i;
      r_f3    <= funct3_i;
      r_rd    <= rd_addr_i;
      r_sdata <= store_data_i;
      r_st    <= (opcode_i == OP_STORE);
    end
  end

  // Result register to WB; wdata/rd hold when nothing is produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_out <= '0;
      r_wreg   <= 1'b0;
      r_wdata  <= '0;
      r_mis    <= 1'b0;
    end else begin
      r_wreg <= 1'b0;
      r_mis  <= 1'b0;
      if (w_idle && valid_i) begin
        if (w_ldst) begin
          r_mis <= w_mis;
        end else begin
          r_rd_out <= rd_addr_i;
          r_wdata  <= wdata_i;
          r_wreg   <= wreg_i && (|rd_addr_i);
        end
      end else if (w_ld_done) begin
        r_rd_out <= r_rd;
        r_wdata  <= w_ld;
        r_wreg   <= |r_rd;
      end
    end
  end

  assign ready_o        = w_idle;
  assign dcache_req_o   = (r_state == S_REQ);
  assign dcache_we_o    = dcache_req_o && r_st;
  assign dcache_addr_o  = {r_addr[XLEN-1:3], 3'b000};
  assign dcache_wdata_o = r_sdata << {w_roff, 3'b000};
  assign dcache_wmask_o = dcache_we_o ? (w_size_mask << w_roff) : 8'h00;

  assign rd_addr_o  = r_rd_out;
  assign wreg_o     = r_wreg;
  assign wdata_o    = r_wdata;
  assign misalign_o = r_mis;

  assign mem_back_rd_addr_o = r_rd_out;
  assign mem_back_wreg_o    = r_wreg;
  assign mem_back_wdata_o   = r_wdata;

endmodule
